// File: rtl/timer_reg_bank.sv
// Timer register bank: TCR/TDR/TIER/TISR/THCSR/TCMPi decode, compare-match status with W1C, registered irq.
// Writes commit on the edge ending wr_en; rdata/pslverr are combinational; irq follows a match by two edges.
module timer_reg_bank #(
  parameter int NUM_CMP = 4,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         pstrb,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [31:0]        rdata,
  output logic               pslverr,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               halt_ack,
  output logic               timer_en,
  output logic               div_en,
  output logic [3:0]         div_val,
  output logic               halt_req,
  output logic               tdr0_wr_sel,
  output logic               tdr1_wr_sel,
  output logic               cnt_clr,
  output logic               irq
);

  localparam int HI_W = CNT_W - 32;

  typedef struct packed {
    logic [3:0] div_val;
    logic       div_en;
    logic       timer_en;
  } tcr_t;

  localparam tcr_t TCR_RST = '{div_val: 4'd1, div_en: 1'b0, timer_en: 1'b0};

  function automatic logic [31:0] strb_merge(input logic [31:0] old_dat,
                                             input logic [31:0] new_dat,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_dat[8*b +: 8];
    end
    return res;
  endfunction

  tcr_t                tcr_q;
  tcr_t                tcr_wr;
  logic                tcr_err;
  logic                timer_en_d;
  logic                tcr_sel;
  logic                tier_sel;
  logic                tisr_sel;
  logic                thcsr_sel;
  logic [NUM_CMP-1:0]  int_en;
  logic [NUM_CMP-1:0]  status;
  logic [NUM_CMP-1:0]  match;
  logic [NUM_CMP-1:0]  match_d;
  logic [NUM_CMP-1:0]  w1c;
  logic [NUM_CMP-1:0]  cmp_lo_sel;
  logic [NUM_CMP-1:0]  cmp_hi_sel;
  logic [31:0]         tcmp_lo [NUM_CMP];
  logic [HI_W-1:0]     tcmp_hi [NUM_CMP];
  logic [31:0]         hi_ext  [NUM_CMP];
  logic [31:0]         hi_next [NUM_CMP];
  logic [HI_W-1:0]     snap;
  logic                snap_valid;
  logic [31:0]         cnt_hi;
  logic [31:0]         snap_ext;
  logic [31:0]         rd_mux;

  // Write decode
  always_comb begin
    tcr_sel     = wr_en && (addr == 12'h000);
    tdr0_wr_sel = wr_en && (addr == 12'h004);
    tdr1_wr_sel = wr_en && (addr == 12'h008);
    tier_sel    = wr_en && (addr == 12'h00C);
    tisr_sel    = wr_en && (addr == 12'h010);
    thcsr_sel   = wr_en && (addr == 12'h014);
    for (int i = 0; i < NUM_CMP; i++) begin
      cmp_lo_sel[i] = wr_en && (addr == 12'(32 + 8 * i));
      cmp_hi_sel[i] = wr_en && (addr == 12'(36 + 8 * i));
    end
  end

  // Candidate TCR value and its legality; an illegal write leaves every field untouched
  always_comb begin
    tcr_wr = tcr_q;
    if (pstrb[0]) begin
      tcr_wr.div_en   = wdata[1];
      tcr_wr.timer_en = wdata[0];
    end
    if (pstrb[1]) tcr_wr.div_val = wdata[11:8];
    tcr_err = (pstrb[1] && (wdata[11:8] > 4'd8)) ||
              (tcr_q.timer_en && ((tcr_wr.div_en != tcr_q.div_en) ||
                                  (tcr_wr.div_val != tcr_q.div_val)));
  end

  assign pslverr  = tcr_sel & tcr_err;
  assign timer_en = tcr_q.timer_en;
  assign div_en   = tcr_q.div_en;
  assign div_val  = tcr_q.div_val;
  assign cnt_clr  = timer_en_d & ~tcr_q.timer_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcr_q      <= TCR_RST;
      timer_en_d <= 1'b0;
      int_en     <= '0;
      halt_req   <= 1'b0;
    end else begin
      timer_en_d <= tcr_q.timer_en;
      if (tcr_sel && !tcr_err)  tcr_q    <= tcr_wr;
      if (tier_sel && pstrb[0]) int_en   <= wdata[NUM_CMP-1:0];
      if (thcsr_sel && pstrb[0]) halt_req <= wdata[0];
    end
  end

  // Upper counter word held from a TDR0 read so the following TDR1 read is coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (rd_en && (addr == 12'h004)) begin
      snap       <= cnt[CNT_W-1:32];
      snap_valid <= 1'b1;
    end else if ((rd_en && (addr == 12'h008)) || tdr0_wr_sel || tdr1_wr_sel) begin
      snap_valid <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CMP; i++) begin
      hi_ext[i]           = '0;
      hi_ext[i][HI_W-1:0] = tcmp_hi[i];
      hi_next[i]          = strb_merge(hi_ext[i], wdata, pstrb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CMP; i++) begin
        tcmp_lo[i] <= '1;
        tcmp_hi[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (cmp_lo_sel[i]) tcmp_lo[i] <= strb_merge(tcmp_lo[i], wdata, pstrb);
        if (cmp_hi_sel[i]) tcmp_hi[i] <= hi_next[i][HI_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CMP; i++) begin
      match[i] = (cnt == {tcmp_hi[i], tcmp_lo[i]});
    end
    w1c = (tisr_sel && pstrb[0]) ? wdata[NUM_CMP-1:0] : '0;
  end

  // Status sets only on a match rising edge; a same-cycle set beats the W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_d <= '0;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      match_d <= match;
      status  <= (status & ~w1c) | (match & ~match_d);
      irq     <= |(status & int_en);
    end
  end

  always_comb begin
    cnt_hi             = '0;
    cnt_hi[HI_W-1:0]   = cnt[CNT_W-1:32];
    snap_ext           = '0;
    snap_ext[HI_W-1:0] = snap;
    rd_mux             = '0;
    case (addr)
      12'h000: rd_mux = {20'd0, tcr_q.div_val, 6'd0, tcr_q.div_en, tcr_q.timer_en};
      12'h004: rd_mux = cnt[31:0];
      12'h008: rd_mux = snap_valid ? snap_ext : cnt_hi;
      12'h00C: rd_mux[NUM_CMP-1:0] = int_en;
      12'h010: rd_mux[NUM_CMP-1:0] = status;
      12'h014: rd_mux[1:0] = {halt_ack, halt_req};
      default: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (addr == 12'(32 + 8 * i)) rd_mux = tcmp_lo[i];
          if (addr == 12'(36 + 8 * i)) rd_mux = hi_ext[i];
        end
      end
    endcase
  end

  assign rdata = rd_en ? rd_mux : '0;

endmodule

// File: tb/tb_timer_reg_bank.sv
// Self-checking bench for timer_reg_bank: directed register-map scenarios then random traffic
// compared cycle by cycle against a behavioural model of the register bank.
module tb_timer_reg_bank;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  pstrb;
  logic        wr_en, rd_en;
  logic [31:0] rdata;
  logic        pslverr;
  logic [63:0] cnt;
  logic        halt_ack;
  logic        timer_en, div_en, halt_req, tdr0_wr_sel, tdr1_wr_sel, cnt_clr, irq;
  logic [3:0]  div_val;

  timer_reg_bank #(.NUM_CMP(NC), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .pstrb(pstrb),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .pslverr(pslverr), .cnt(cnt),
    .halt_ack(halt_ack), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
    .halt_req(halt_req), .tdr0_wr_sel(tdr0_wr_sel), .tdr1_wr_sel(tdr1_wr_sel),
    .cnt_clr(cnt_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic          m_ten, m_den, m_ten_d, m_hreq, m_irq, m_sv;
  logic [3:0]    m_dval;
  logic [63:0]   m_cmp [NC];
  logic [NC-1:0] m_ien, m_st, m_prev;
  logic [31:0]   m_snap;

  logic [31:0] s_rdata;
  logic        s_err, s_irq, s_clr;
  logic [11:0] alist [18];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ten = 0; m_den = 0; m_ten_d = 0; m_dval = 4'd1;
    m_hreq = 0; m_irq = 0; m_sv = 0; m_snap = 0;
    m_ien = 0; m_st = 0; m_prev = 0;
    for (int i = 0; i < NC; i++) m_cmp[i] = '1;
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit tcr_bad();
    bit bad_div, chg;
    bad_div = pstrb[1] && (wdata[11:8] > 4'd8);
    chg = (pstrb[0] && (wdata[1] != m_den)) || (pstrb[1] && (wdata[11:8] != m_dval));
    return bad_div || (m_ten && chg);
  endfunction

  function automatic bit is_cmp(input int a);
    return (a >= 32) && (a < 32 + 8 * NC) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] exp_rd();
    int a = int'(addr);
    logic [31:0] r = 0;
    if (!rd_en) return 0;
    case (a)
      0:  r = {20'd0, m_dval, 6'd0, m_den, m_ten};
      4:  r = cnt[31:0];
      8:  r = m_sv ? m_snap : cnt[63:32];
      12: r = 32'(m_ien);
      16: r = 32'(m_st);
      20: r = {30'd0, halt_ack, m_hreq};
      default: if (is_cmp(a)) r = (a % 8 == 0) ? m_cmp[(a-32)/8][31:0] : m_cmp[(a-32)/8][63:32];
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic [NC-1:0] hit, clr, nst;
    int a = int'(addr);
    for (int i = 0; i < NC; i++) hit[i] = (cnt == m_cmp[i]);
    clr = (wr_en && a == 16 && pstrb[0]) ? wdata[NC-1:0] : '0;
    nst = (m_st & ~clr) | (hit & ~m_prev);
    m_irq = |(m_st & m_ien);
    m_prev = hit;
    m_st = nst;
    m_ten_d = m_ten;
    if (rd_en && a == 4) begin m_snap = cnt[63:32]; m_sv = 1; end
    if (rd_en && a == 8) m_sv = 0;
    if (wr_en) begin
      case (a)
        0: if (!tcr_bad()) begin
             if (pstrb[0]) begin m_den = wdata[1]; m_ten = wdata[0]; end
             if (pstrb[1]) m_dval = wdata[11:8];
           end
        4, 8: m_sv = 0;
        12: if (pstrb[0]) m_ien = wdata[NC-1:0];
        16: ;
        20: if (pstrb[0]) m_hreq = wdata[0];
        default: if (is_cmp(a)) begin
          if (a % 8 == 0) m_cmp[(a-32)/8][31:0]  = mrg(m_cmp[(a-32)/8][31:0], wdata, pstrb);
          else            m_cmp[(a-32)/8][63:32] = mrg(m_cmp[(a-32)/8][63:32], wdata, pstrb);
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_rdata = rdata; s_err = pslverr; s_irq = irq; s_clr = cnt_clr;
    check("rdata", rdata, exp_rd());
    check("pslverr", pslverr, wr_en && addr == 12'h000 && tcr_bad());
    check("tdr0_wr_sel", tdr0_wr_sel, wr_en && addr == 12'h004);
    check("tdr1_wr_sel", tdr1_wr_sel, wr_en && addr == 12'h008);
    check("irq", irq, m_irq);
    check("cnt_clr", cnt_clr, m_ten_d & ~m_ten);
    check("tcr_out", {timer_en, div_en, div_val}, {m_ten, m_den, m_dval});
    check("halt_req", halt_req, m_hreq);
    @(posedge clk);
    model_step();
    #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; pstrb = s; wr_en = 1; cycle();
  endtask

  task automatic rd(input logic [11:0] a);
    addr = a; rd_en = 1; cycle();
  endtask

  initial begin
    addr = 0; wdata = 0; pstrb = 0; wr_en = 0; rd_en = 0; cnt = 0; halt_ack = 0;
    alist = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h020, 12'h024, 12'h028,
              12'h02C, 12'h030, 12'h034, 12'h038, 12'h03C, 12'h040, 12'h044, 12'h022, 12'h3FC};
    model_reset();
    #1 rst_n = 0;
    #2;
    check("rst_div_val", div_val, 4'd1);
    check("rst_timer_en", timer_en, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_halt_req", halt_req, 1'b0);
    @(posedge clk); #1 rst_n = 1;

    // Reset read sweep
    rd(12'h000); check("sweep_tcr", s_rdata, 32'h100);
    for (int i = 0; i < NC; i++) begin
      rd(12'(32 + 8 * i)); check("sweep_cmp_lo", s_rdata, 32'hFFFF_FFFF);
      rd(12'(36 + 8 * i)); check("sweep_cmp_hi", s_rdata, 32'hFFFF_FFFF);
    end
    rd(12'h00C); check("sweep_tier", s_rdata, 0);
    rd(12'h010); check("sweep_tisr", s_rdata, 0);
    rd(12'h014); check("sweep_thcsr", s_rdata, 0);
    rd(12'h040); check("sweep_cmp4", s_rdata, 0);
    rd(12'h3FC); check("sweep_3fc", s_rdata, 0);

    // Illegal divider and locked divider
    wr(12'h000, 32'h901, 4'hF); check("div9_err", s_err, 1);
    rd(12'h000); check("div9_tcr", s_rdata, 32'h100);
    wr(12'h000, 32'h301, 4'hF); check("div3_err", s_err, 0);
    rd(12'h000); check("div3_tcr", s_rdata, 32'h301);
    wr(12'h000, 32'h401, 4'hF); check("locked_err", s_err, 1);
    rd(12'h000); check("locked_tcr", s_rdata, 32'h301);

    // Counter clear pulse on timer_en 1->0
    wr(12'h000, 32'h0, 4'h1); check("clr_wr_cycle", s_clr, 0);
    cycle(); check("clr_pulse", s_clr, 1);
    cycle(); check("clr_after", s_clr, 0);

    // Snapshot
    cnt = 64'h1_FFFF_FFFF;
    rd(12'h004); check("snap_tdr0", s_rdata, 32'hFFFF_FFFF);
    cnt = 64'h2_0000_0005;
    rd(12'h008); check("snap_tdr1", s_rdata, 32'h1);
    rd(12'h008); check("live_tdr1", s_rdata, 32'h2);

    // Match, interrupt, W1C
    cnt = 0;
    wr(12'h030, 32'h10, 4'hF);
    wr(12'h034, 32'h0, 4'hF);
    wr(12'h00C, 32'h4, 4'h1);
    cnt = 64'h0F; cycle();
    cnt = 64'h10; cycle();
    rd(12'h010); check("match_tisr", s_rdata, 32'h4); check("irq_not_yet", s_irq, 0);
    cycle(); check("irq_set", s_irq, 1);
    cnt = 64'h11;
    wr(12'h010, 32'h4, 4'h1);
    cycle(); check("irq_hold", s_irq, 1);
    cycle(); check("irq_clear", s_irq, 0);
    cnt = 64'h10;
    wr(12'h010, 32'h4, 4'h1);
    rd(12'h010); check("set_wins", s_rdata, 32'h4);
    wr(12'h010, 32'h4, 4'h1);
    rd(12'h010); check("held_no_reset", s_rdata, 32'h0);

    // Halt
    halt_ack = 1;
    wr(12'h014, 32'h1, 4'h1);
    rd(12'h014); check("thcsr", s_rdata, 32'h3);
    halt_ack = 0;

    // Random traffic
    for (int it = 0; it < 800; it++) begin
      int op = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: cnt = m_cmp[$urandom_range(0, NC-1)];
        1: cnt = m_cmp[$urandom_range(0, NC-1)] + 64'd1;
        2: cnt = {$urandom, $urandom};
        default: ;
      endcase
      halt_ack = 1'($urandom_range(0, 1));
      addr  = alist[$urandom_range(0, 17)];
      wdata = $urandom;
      if ($urandom_range(0, 1) == 1) wdata[11:8] = 4'($urandom_range(0, 8));
      pstrb = 4'($urandom_range(0, 15));
      if (op < 3) wr_en = 1;
      else if (op < 6) rd_en = 1;
      cycle();
    end

    // Asynchronous reset mid-operation
    wr(12'h00C, 32'hF, 4'h1);
    wr(12'h014, 32'h1, 4'h1);
    rst_n = 0;
    #1;
    check("mid_rst_irq", irq, 0);
    check("mid_rst_div_val", div_val, 4'd1);
    check("mid_rst_timer_en", timer_en, 0);
    check("mid_rst_halt_req", halt_req, 0);
    check("mid_rst_cnt_clr", cnt_clr, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    rd(12'h00C); check("post_rst_tier", s_rdata, 0);
    rd(12'h020); check("post_rst_cmp0", s_rdata, 32'hFFFF_FFFF);
    rd(12'h000); check("post_rst_tcr", s_rdata, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
